// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Purpose  : Measures high time and period of an asynchronous PWM input,
//             publishing both counts with a one-cycle valid pulse and flagging
//             a stuck input when no rising edge arrives within MAX_PERIOD.
//  Option   : PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-cycle stability filter
//             after the synchronizer (pulses of 1-2 cycles are ignored).
//  Revision : 1.0  initial release
// ============================================================================
module pwm_capture #(
    parameter int PWM_INTERVAL = 1200,
    parameter int MAX_PERIOD   = 2 * PWM_INTERVAL,
    localparam int CW          = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] high_count,
    output logic [CW-1:0] period_count,
    output logic          valid,
    output logic          stuck,
    output logic          stuck_level
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic sync1;
    logic s;
    logic lvl;
    logic lvl_d;

    // Two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            s     <= sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic       filt;
    logic       filt_d;
    logic [1:0] stab;

    // Filtered level follows s only after s differs for 3 consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b0;
            filt_d <= 1'b0;
            stab   <= 2'd0;
        end else begin
            filt_d <= filt;
            if (s == filt) begin
                stab <= 2'd0;
            end else if (stab == 2'd2) begin
                filt <= s;
                stab <= 2'd0;
            end else begin
                stab <= stab + 2'd1;
            end
        end
    end

    assign lvl   = filt;
    assign lvl_d = filt_d;
`else
    logic s_d;

    // One-cycle delayed copy of the synchronized level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign lvl   = s;
    assign lvl_d = s_d;
`endif

    logic rise;
    logic fall;

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    state_t        state,        state_nx;
    logic [CW-1:0] cnt,          cnt_nx;
    logic [CW-1:0] hcnt,         hcnt_nx;
    logic [CW-1:0] high_nx;
    logic [CW-1:0] period_nx;
    logic          valid_nx;
    logic          stuck_nx;
    logic          stuck_level_nx;

    // State and measurement registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            high_count   <= '0;
            period_count <= '0;
            valid        <= 1'b0;
            stuck        <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hcnt         <= hcnt_nx;
            high_count   <= high_nx;
            period_count <= period_nx;
            valid        <= valid_nx;
            stuck        <= stuck_nx;
            stuck_level  <= stuck_level_nx;
        end
    end

    // Next-state logic: count high/low phases, publish on rise, time out at MAX_PERIOD
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        hcnt_nx        = hcnt;
        high_nx        = high_count;
        period_nx      = period_count;
        valid_nx       = 1'b0;
        stuck_nx       = stuck;
        stuck_level_nx = stuck_level;

        case (state)
            IDLE: begin
                // First rise only starts a measurement; counter is held here
                if (rise) begin
                    state_nx = HIGH;
                    cnt_nx   = CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt == CNT_MAX) begin
                    state_nx       = IDLE;
                    stuck_nx       = 1'b1;
                    stuck_level_nx = s;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                    if (fall) begin
                        hcnt_nx  = cnt;
                        state_nx = LOW;
                    end
                end
            end
            LOW: begin
                // A rise wins over a simultaneous timeout
                if (rise) begin
                    high_nx   = hcnt;
                    period_nx = cnt;
                    valid_nx  = 1'b1;
                    stuck_nx  = 1'b0;
                    cnt_nx    = CNT_ONE;
                    state_nx  = HIGH;
                end else if (cnt == CNT_MAX) begin
                    state_nx       = IDLE;
                    stuck_nx       = 1'b1;
                    stuck_level_nx = s;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_capture
//  Purpose  : Directed self-checking bench for pwm_capture; expected
//             measurements are queued when a completing rise is driven and
//             compared when valid pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

    localparam int MAXP = 2400;
    localparam int CW   = $clog2(MAXP + 1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT  = 6;
`else
    localparam int LAT  = 3;
`endif

    typedef struct {
        int hi;
        int per;
        int at;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] high_count;
    logic [CW-1:0] period_count;
    logic          valid;
    logic          stuck;
    logic          stuck_level;

    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   last_h = 0;
    int   last_l = 0;
    bit   armed  = 1'b0;
    exp_t sb[$];

    pwm_capture dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    // Free-running clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int p);
        exp_t e;
        e.hi  = h;
        e.per = p;
        e.at  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic rise();
        pwm_in = 1'b1;
        if (armed) push(last_h, last_h + last_l);
        armed = 1'b1;
    endtask

    task automatic wave(input int h, input int l);
        rise();
        hold(h);
        pwm_in = 1'b0;
        hold(l);
        last_h = h;
        last_l = l;
    endtask

    // Scoreboard: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid observed=1 expected=0 at cycle %0d", cyc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.at);
                check("high_count", high_count, e.hi);
                check("period_count", period_count, e.per);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        hold(3);
        @(negedge clk);
        check("rst_high_count", high_count, 0);
        check("rst_period_count", period_count, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_stuck_level", stuck_level, 0);
        rst = 1'b0;
        hold(2);

        // 3 high / 5 low: first rise silent, then 3/8 per period
        repeat (4) wave(3, 5);
        hold(5);
        check("w35_high", high_count, 3);
        check("w35_period", period_count, 8);
        check("w35_stuck", stuck, 0);

        // Steady 300 / 1200
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        armed = 1'b0;
        hold(2);
        repeat (3) wave(300, 900);

        // Hold high after one rise until timeout
        begin
            int rem;
            rise();
            hold(LAT + 2399);
            @(negedge clk);
            check("stuck_before", stuck, 0);
            @(posedge clk);
            @(negedge clk);
            check("stuck_set", stuck, 1);
            check("stuck_level", stuck_level, 1);
            check("stuck_high_kept", high_count, 300);
            check("stuck_period_kept", period_count, 1200);
            @(posedge clk);
            #1;
            rem = 99 - LAT;
            hold(rem);
            pwm_in = 1'b0;
            armed  = 1'b0;
            hold(100);
            check("stuck_hold", stuck, 1);
        end
        wave(4, 6);
        wave(4, 6);
        check("stuck_cleared", stuck, 0);

        // Reset during the low phase of a 4/10 waveform
        rise();
        hold(4);
        pwm_in = 1'b0;
        hold(2);
        rst = 1'b1;
        armed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_high", high_count, 0);
        check("midrst_period", period_count, 0);
        check("midrst_valid", valid, 0);
        check("midrst_stuck", stuck, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        hold(2);
        wave(4, 6);
        check("midrst_no_valid_yet", period_count, 0);
        wave(4, 6);

        // 2-cycle glitch inside the low phase
        rise();
        hold(4);
        pwm_in = 1'b0;
        hold(3);
        pwm_in = 1'b1;
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        push(4, 7);
`endif
        hold(2);
        pwm_in = 1'b0;
        hold(1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        last_h = 4;
        last_l = 6;
`else
        last_h = 2;
        last_l = 1;
`endif
        wave(4, 6);
        wave(4, 6);
        hold(20);
        check("final_high", high_count, 4);
        check("final_period", period_count, 10);
        check("queue_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, the nominal PWM period in clk cycles (100us at 12MHz).
REQ-002 SHALL have parameter MAX_PERIOD, default 2*PWM_INTERVAL, the number of cycles without a rising edge that counts as a timeout.
REQ-003 SHALL define CW = $clog2(MAX_PERIOD+1) as the width of all count outputs.
REQ-004 Port: clk  input  1  single clock; all logic is on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Port: pwm_in  input  1  asynchronous PWM signal to be measured.
REQ-007 Port: high_count  output  CW  high-time of the last complete period, in cycles.
REQ-008 Port: period_count  output  CW  length of the last complete period, rising edge to rising edge, in cycles.
REQ-009 Port: valid  output  1  single-cycle pulse when high_count and period_count update.
REQ-010 Port: stuck  output  1  level: no rising edge within MAX_PERIOD cycles.
REQ-011 Port: stuck_level  output  1  synchronized pwm_in level captured when stuck is set.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer; all further logic SHALL use only the second flop (s) and its one-cycle-delayed copy (s_d).
REQ-013 Edge detection: rise = s & ~s_d; fall = ~s & s_d.
REQ-014 FSM states SHALL be IDLE, HIGH and LOW.
REQ-015 IDLE: the counter is held; on rise, go to HIGH and load cnt=1.
REQ-016 HIGH: cnt increments by 1 per cycle; on fall, latch hcnt <= cnt (the pre-increment value) and go to LOW.
REQ-017 LOW: cnt increments; on rise, perform all of the following:
- high_count <= hcnt
- period_count <= cnt (pre-increment value)
- valid=1 for one cycle
- stuck <= 0
- cnt <= 1
- state <= HIGH
REQ-018 Example: 3 cycles high, 5 cycles low SHALL yield period_count=8 and high_count=3.
REQ-019 Latency: valid SHALL be registered and assert on the 3rd clk edge after the first edge at which pwm_in is sampled high.
REQ-020 Timeout: in HIGH or LOW, when cnt reaches MAX_PERIOD with no rise, the block SHALL:
- set stuck=1 and stuck_level=s
- leave high_count and period_count unchanged
- not pulse valid
- go to IDLE
REQ-021 cnt SHALL never wrap; the timeout in REQ-020 bounds it at MAX_PERIOD.
REQ-022 A rise in the same cycle that cnt reaches MAX_PERIOD SHALL take priority over the timeout: measurement is published, stuck is not set.
REQ-023 The first rise after reset or IDLE SHALL only start a measurement and SHALL NOT produce valid.
REQ-024 A pulse shorter than 1 synchronized cycle SHALL be invisible; no other minimum-width rule SHALL apply.

Reset
REQ-025 On rst, the block SHALL set:
- state=IDLE
- cnt, hcnt, high_count, period_count = 0
- valid=0, stuck=0, stuck_level=0
- both synchronizer flops and s_d = 0
REQ-026 rst asserted mid-measurement SHALL discard the partial measurement; the first valid after release SHALL require two rising edges.

Configuration
REQ-027 Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- When defined: a 3-cycle stability filter SHALL sit after the synchronizer; the filtered level changes only after s holds a new value for 3 consecutive cycles. Pulses of 1-2 cycles SHALL be ignored, and valid latency SHALL increase by 3 cycles.
- When undefined: no filter; s drives edge detection directly.

Verification
REQ-028 Reset, then 3 high / 5 low repeated -> first valid after the second rise; period_count=8, high_count=3; valid exactly 1 cycle wide.
REQ-029 Steady 300 high / 1200 period -> valid every 1200 cycles with high_count=300 and period_count=1200; first valid 3 cycles after the second pwm_in rise.
REQ-030 Hold pwm_in=1 for 2500 cycles after one rise -> stuck=1 and stuck_level=1 exactly when cnt=2400; counts unchanged; no valid. The next two rises -> valid, stuck=0.
REQ-031 rst for 1 cycle during the low phase of a 4/10 waveform -> all outputs 0; the next valid reports 4/10 only after two further rises.
REQ-032 2-cycle glitch high within the low phase -> with the macro defined, no change to the 4/10 results; without it, a valid with period_count equal to the cycles to the glitch.
